// File: rtl/bram_arb_pkg.sv
// Shared constants for the BRAM port arbiter slice.
package bram_arb_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 12;

    // Port identifiers; also the encoding of the round-robin history bit.
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_e;

endpackage : bram_arb_pkg

// File: rtl/bram_port_arbiter_if.sv
// Requester handshakes plus BRAM pins of the shared-BRAM arbiter.
interface bram_port_arbiter_if
    import bram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);

    // Port A: instruction fetch, read-only
    logic                  a_req_valid;
    logic                  a_req_ready;
    logic [ADDR_WIDTH-1:0] a_req_addr;
    logic                  a_rsp_valid;
    logic                  a_rsp_ready;
    logic [DATA_WIDTH-1:0] a_rsp_data;

    // Port B: load/store
    logic                  b_req_valid;
    logic                  b_req_ready;
    logic                  b_req_we;
    logic [ADDR_WIDTH-1:0] b_req_addr;
    logic [DATA_WIDTH-1:0] b_req_wdata;
    logic                  b_rsp_valid;
    logic                  b_rsp_ready;
    logic [DATA_WIDTH-1:0] b_rsp_data;

    // BRAM pins
    logic [ADDR_WIDTH-1:0] bram_rd_addr;
    logic [ADDR_WIDTH-1:0] bram_wr_addr;
    logic [DATA_WIDTH-1:0] bram_di;
    logic                  bram_we;
    logic                  bram_re;
    logic [DATA_WIDTH-1:0] bram_do;
    logic                  bram_do_valid;

    // Arbiter side
    modport slave (
        input  a_req_valid, a_req_addr, a_rsp_ready,
        input  b_req_valid, b_req_we, b_req_addr, b_req_wdata, b_rsp_ready,
        input  bram_do, bram_do_valid,
        output a_req_ready, a_rsp_valid, a_rsp_data,
        output b_req_ready, b_rsp_valid, b_rsp_data,
        output bram_rd_addr, bram_wr_addr, bram_di, bram_we, bram_re
    );

    // Requesters and BRAM side
    modport master (
        output a_req_valid, a_req_addr, a_rsp_ready,
        output b_req_valid, b_req_we, b_req_addr, b_req_wdata, b_rsp_ready,
        output bram_do, bram_do_valid,
        input  a_req_ready, a_rsp_valid, a_rsp_data,
        input  b_req_ready, b_rsp_valid, b_rsp_data,
        input  bram_rd_addr, bram_wr_addr, bram_di, bram_we, bram_re
    );

endinterface : bram_port_arbiter_if

// File: rtl/bram_rsp_slot.sv
// One-entry read-response register with bypass-on-drain free indication.
module bram_rsp_slot
    import bram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  rsp_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  slot_free_c
);

    // Slot can take new data if empty or being drained this cycle.
    assign slot_free_c = !rsp_valid || rsp_ready;

    // Load wins over drain so a same-cycle drain+refill stays valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_data  <= load_data;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule : bram_rsp_slot

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM between fetch (A) and load/store (B).
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                CLK,
    input  logic                RST_N,
    bram_port_arbiter_if.slave  bus
);

    port_id_e              last_grant;
    logic                  slot_free_a;
    logic                  slot_free_b;
    logic                  elig_a;
    logic                  elig_b;
    logic                  grant_a;
    logic                  grant_b;
    logic                  load_a;
    logic                  load_b;
    logic                  a_rsp_valid;
    logic                  b_rsp_valid;
    logic [DATA_WIDTH-1:0] a_rsp_data;
    logic [DATA_WIDTH-1:0] b_rsp_data;
    logic [ADDR_WIDTH-1:0] rd_addr_c;

    // Eligibility and single-winner grant; ties go to the port not served last.
    always_comb begin
        elig_a  = bus.a_req_valid && slot_free_a;
        elig_b  = bus.b_req_valid && (bus.b_req_we || slot_free_b);
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (elig_a && elig_b) begin
            if (last_grant == PORT_A) begin
                grant_b = 1'b1;
            end else begin
                grant_a = 1'b1;
            end
        end else begin
            grant_a = elig_a;
            grant_b = elig_b;
        end
    end

    // Round-robin history; reset to B so A wins the first contention.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_grant <= PORT_B;
        end else if (grant_a) begin
            last_grant <= PORT_A;
        end else if (grant_b) begin
            last_grant <= PORT_B;
        end
    end

    // Read address follows the winner; idle cycles present A's address.
    assign rd_addr_c = grant_b ? bus.b_req_addr : bus.a_req_addr;

    assign bus.a_req_ready  = grant_a;
    assign bus.b_req_ready  = grant_b;
    assign bus.bram_rd_addr = rd_addr_c;
    assign bus.bram_wr_addr = bus.b_req_addr;
    assign bus.bram_di      = bus.b_req_wdata;
    assign bus.bram_we      = grant_b && bus.b_req_we;
    assign bus.bram_re      = grant_a || (grant_b && !bus.b_req_we);

    // BRAM output is captured at the posedge closing the grant cycle.
    assign load_a = grant_a && bus.bram_do_valid;
    assign load_b = grant_b && !bus.b_req_we && bus.bram_do_valid;

    bram_rsp_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot_a (
        .clk         (CLK),
        .rst_n       (RST_N),
        .load        (load_a),
        .load_data   (bus.bram_do),
        .rsp_ready   (bus.a_rsp_ready),
        .rsp_valid   (a_rsp_valid),
        .rsp_data    (a_rsp_data),
        .slot_free_c (slot_free_a)
    );

    bram_rsp_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot_b (
        .clk         (CLK),
        .rst_n       (RST_N),
        .load        (load_b),
        .load_data   (bus.bram_do),
        .rsp_ready   (bus.b_rsp_ready),
        .rsp_valid   (b_rsp_valid),
        .rsp_data    (b_rsp_data),
        .slot_free_c (slot_free_b)
    );

    assign bus.a_rsp_valid = a_rsp_valid;
    assign bus.a_rsp_data  = a_rsp_data;
    assign bus.b_rsp_valid = b_rsp_valid;
    assign bus.b_rsp_data  = b_rsp_data;

endmodule : bram_port_arbiter
